param_sync_fifo: RTL and testbench

- Parametrised synchronous FIFO. Generalises the team's 8x8 FIFO in data width and depth.
- Adds simultaneous read/write, fill count, programmable almost-full/almost-empty flags, and error pulses.
- Adds a selectable full-time policy: reject the write, or overwrite the oldest entry.
- Drop-in buffer between producer/consumer blocks in the component library; single clock domain.

---
 rtl/param_sync_fifo.sv | 105 ++++++++++
 tb/tb_param_sync_fifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with count, threshold flags,
// error pulses and a selectable reject/overwrite policy when full.
module param_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 8,
    parameter int OVERWRITE  = 0,
    parameter int AFULL_THR  = DEPTH - 1,
    parameter int AEMPTY_THR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_enable,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     read_enable,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_THR);
    localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_THR);
    localparam bit OW = (OVERWRITE != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic w_is_full;
    logic w_is_empty;
    logic w_rd_acc;
    logic w_full_block;
    logic w_drop;
    logic w_wr_acc;

    assign w_is_full  = (r_count == C_DEPTH);
    assign w_is_empty = (r_count == '0);
    assign w_rd_acc   = read_enable & ~w_is_empty;

    // A write meeting a full FIFO with no concurrent read either gets rejected
    // or, in overwrite mode, pushes the oldest entry out (rd_ptr advances).
    assign w_full_block = write_enable & w_is_full & ~w_rd_acc;
    assign w_drop       = w_full_block & OW;
    assign w_wr_acc     = write_enable & ~(w_full_block & ~OW);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            r_overflow   <= w_full_block;
            r_underflow  <= read_enable & w_is_empty;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc || w_drop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
            if (w_wr_acc && !w_rd_acc && !w_drop) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage is never cleared; reset only blocks a write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign count        = r_count;
    assign full         = w_is_full;
    assign empty        = w_is_empty;
    assign almost_full  = (r_count >= C_AFULL);
    assign almost_empty = (r_count <= C_AEMPTY);

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - scoreboard bench driving a reject-mode and an overwrite-mode FIFO in lockstep.
module tb_param_sync_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_enable = 1'b0;
    logic       read_enable = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] data_out0, data_out1;
    logic       dv0, dv1, full0, full1, empty0, empty1, af0, af1, ae0, ae1;
    logic       ovf0, ovf1, unf0, unf1;
    logic [3:0] count0, count1;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] q0[$], q1[$];
    logic [7:0] sb0[$], sb1[$];
    bit e_dv0, e_dv1, e_ov0, e_ov1, e_un0, e_un1;

    always #5 clk = ~clk;

    param_sync_fifo #(.DATA_W(8), .DEPTH(8), .OVERWRITE(0)) u_rej (
        .clk(clk), .rst(rst), .write_enable(write_enable), .data_in(data_in),
        .read_enable(read_enable), .data_out(data_out0), .data_valid(dv0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    param_sync_fifo #(.DATA_W(8), .DEPTH(8), .OVERWRITE(1)) u_ovw (
        .clk(clk), .rst(rst), .write_enable(write_enable), .data_in(data_in),
        .read_enable(read_enable), .data_out(data_out1), .data_valid(dv1),
        .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the FIFO is a queue; reads pop the front, writes push the back.
    task automatic cycle(input bit we, input logic [7:0] d, input bit re, input bit rs);
        int n;
        write_enable = we; data_in = d; read_enable = re; rst = rs;
        if (rs) begin
            q0.delete(); q1.delete();
            {e_dv0, e_ov0, e_un0, e_dv1, e_ov1, e_un1} = '0;
        end else begin
            n = q0.size();
            e_dv0 = re && n > 0;
            e_un0 = re && n == 0;
            e_ov0 = we && n == 8 && !e_dv0;
            if (e_dv0) sb0.push_back(q0.pop_front());
            if (we && !e_ov0) q0.push_back(d);

            n = q1.size();
            e_dv1 = re && n > 0;
            e_un1 = re && n == 0;
            e_ov1 = we && n == 8 && !e_dv1;
            if (e_dv1) sb1.push_back(q1.pop_front());
            if (e_ov1) void'(q1.pop_front());
            if (we) q1.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("count_rej", count0, q0.size());
        chk("full_rej", full0, q0.size() == 8);
        chk("empty_rej", empty0, q0.size() == 0);
        chk("afull_rej", af0, q0.size() >= 7);
        chk("aempty_rej", ae0, q0.size() <= 1);
        chk("ovf_rej", ovf0, e_ov0);
        chk("unf_rej", unf0, e_un0);
        chk("dv_rej", dv0, e_dv0);
        chk("count_ovw", count1, q1.size());
        chk("full_ovw", full1, q1.size() == 8);
        chk("empty_ovw", empty1, q1.size() == 0);
        chk("afull_ovw", af1, q1.size() >= 7);
        chk("aempty_ovw", ae1, q1.size() <= 1);
        chk("ovf_ovw", ovf1, e_ov1);
        chk("unf_ovw", unf1, e_un1);
        chk("dv_ovw", dv1, e_dv1);
        if (rs) begin
            chk("dout_rst_rej", data_out0, 0);
            chk("dout_rst_ovw", data_out1, 0);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents read data.
    always @(posedge clk) begin
        #1;
        if (dv0) begin
            if (sb0.size() == 0) chk("unexpected_dv_rej", 1, 0);
            else chk("rdata_rej", data_out0, sb0.pop_front());
        end
        if (dv1) begin
            if (sb1.size() == 0) chk("unexpected_dv_ovw", 1, 0);
            else chk("rdata_ovw", data_out1, sb1.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);
        // fill, then overfill twice, then drain plus one underflowing read
        for (int i = 0; i < 8; i++) cycle(1, 8'h10 + 8'(i), 0, 0);
        cycle(1, 8'hAA, 0, 0);
        cycle(1, 8'hBB, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 8'h00, 1, 0);
        // read+write on empty, then read it back
        cycle(1, 8'h55, 1, 0);
        cycle(0, 8'h00, 1, 0);
        // read+write on full
        for (int i = 0; i < 8; i++) cycle(1, 8'h20 + 8'(i), 0, 0);
        cycle(1, 8'h77, 1, 0);
        cycle(0, 8'h00, 0, 1);
        // wrap-around streaming at count 1
        cycle(1, 8'hF0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 8'(i), 1, 0);
        cycle(0, 8'h00, 1, 0);
        // reset mid-operation with both enables active
        for (int i = 0; i < 5; i++) cycle(1, 8'h60 + 8'(i), 0, 0);
        cycle(1, 8'h99, 1, 1);
        cycle(1, 8'h3C, 0, 0);
        cycle(0, 8'h00, 1, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 59) == 0);
        end
        for (int i = 0; i < 9; i++) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);
        chk("sb_left_rej", sb0.size(), 0);
        chk("sb_left_ovw", sb1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
